// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter_if
// Purpose  : Bundles the two requester ports and the SRAM pin-side signals
//            of sram_arbiter.
//
// Signals  : p0_* / p1_*   request handshake (valid, write, addr, wdata, done)
//            rdata         shared read-data return
//            mem_*         SRAM address, write data, data-drive enable,
//                          active-low strobes and read data from the pins
//
// Modports : slave  - the arbiter (consumes requests, drives the SRAM side)
//            master - requesters plus the SRAM pin model / top-level pads
//
// Revision : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 8
);
    // Port 0: high-priority requester (video / DMA fetch)
    logic                  p0_valid;
    logic                  p0_write;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic                  p0_done;

    // Port 1: general requester (CPU)
    logic                  p1_valid;
    logic                  p1_write;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p1_done;

    // Shared read return
    logic [DATA_WIDTH-1:0] rdata;

    // SRAM pin side
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic                  mem_dout_en;
    logic [DATA_WIDTH-1:0] mem_din;
    logic                  mem_ce;
    logic                  mem_oe;
    logic                  mem_we;

    modport slave (
        input  p0_valid, p0_write, p0_addr, p0_wdata,
        input  p1_valid, p1_write, p1_addr, p1_wdata,
        input  mem_din,
        output p0_done, p1_done, rdata,
        output mem_addr, mem_dout, mem_dout_en, mem_ce, mem_oe, mem_we
    );

    modport master (
        output p0_valid, p0_write, p0_addr, p0_wdata,
        output p1_valid, p1_write, p1_addr, p1_wdata,
        output mem_din,
        input  p0_done, p1_done, rdata,
        input  mem_addr, mem_dout, mem_dout_en, mem_ce, mem_oe, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Two-port arbiter and access sequencer for one asynchronous SRAM
//            bank. Port 0 is the high-priority requester, port 1 the general
//            one. Each access runs IDLE -> SETUP -> STROBE -> DONE -> IDLE,
//            taking WAIT_STATES+4 clocks from grant to the next grant.
//
// Ports    : clock  - sole clock, rising edge
//            reset  - synchronous, active-high
//            bus    - sram_arbiter_if.slave (requests, done pulses, rdata,
//                     SRAM address/data/strobes)
//
// Params   : ADDR_WIDTH  SRAM address width
//            DATA_WIDTH  SRAM data width
//            WAIT_STATES extra strobe clocks per access, 0..15
//
// Options  : SRAM_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests
//            alternate between the ports; otherwise port 0 always wins.
//
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ADDR_WIDTH  = 19,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic          clock,
    input  logic          reset,
    sram_arbiter_if.slave bus
);

    // The wait counter is 4 bits wide, hence the 0..15 legal range.
    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Access context, frozen from grant until DONE ends
    logic                  r_write;
    logic                  w_write_next;
    logic                  r_grant;          // 0 = port 0, 1 = port 1
    logic                  w_grant_next;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] w_mem_addr_next;
    logic [DATA_WIDTH-1:0] r_mem_dout;
    logic [DATA_WIDTH-1:0] w_mem_dout_next;

    logic [3:0]            r_wait;
    logic [3:0]            w_wait_next;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] w_rdata_next;

    // Registered pin strobes and completion pulses
    logic                  r_mem_ce;
    logic                  w_mem_ce_next;
    logic                  r_mem_oe;
    logic                  w_mem_oe_next;
    logic                  r_mem_we;
    logic                  w_mem_we_next;
    logic                  r_mem_dout_en;
    logic                  w_mem_dout_en_next;
    logic                  r_p0_done;
    logic                  w_p0_done_next;
    logic                  r_p1_done;
    logic                  w_p1_done_next;

    logic                  w_req_any;
    logic                  w_pick;           // port that would win in IDLE

    assign w_req_any = bus.p0_valid | bus.p1_valid;

    // ------------------------------------------------------------------------
    // Arbitration. w_pick is only meaningful when w_req_any is high.
    // ------------------------------------------------------------------------
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    // On a tie the port not served last wins; a lone requester always wins.
    assign w_pick = (bus.p0_valid & bus.p1_valid) ? ~r_last_grant : bus.p1_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if ((r_state == ST_IDLE) && w_req_any) begin
            r_last_grant <= w_pick;
        end
    end
`else
    // Fixed priority: port 1 is chosen only when port 0 is not requesting.
    assign w_pick = ~bus.p0_valid;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, next-context and next-strobe logic.
    // All pin strobes are registered, so they are derived from the state being
    // entered rather than the current one; this keeps them glitch-free and
    // aligned with the state they belong to.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_write_next    = r_write;
        w_grant_next    = r_grant;
        w_mem_addr_next = r_mem_addr;
        w_mem_dout_next = r_mem_dout;
        w_wait_next     = r_wait;
        w_rdata_next    = r_rdata;
        w_p0_done_next  = 1'b0;
        w_p1_done_next  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Requester inputs are only looked at here.
                if (w_req_any) begin
                    w_state_next = ST_SETUP;
                    w_grant_next = w_pick;
                    if (w_pick) begin
                        w_write_next    = bus.p1_write;
                        w_mem_addr_next = bus.p1_addr;
                        w_mem_dout_next = bus.p1_wdata;
                    end else begin
                        w_write_next    = bus.p0_write;
                        w_mem_addr_next = bus.p0_addr;
                        w_mem_dout_next = bus.p0_wdata;
                    end
                end
            end

            ST_SETUP: begin
                w_state_next = ST_STROBE;
                w_wait_next  = C_WAIT_LOAD;
            end

            ST_STROBE: begin
                // Counter saturates at zero; the zero clock is the last strobe
                // clock, giving WAIT_STATES+1 strobe clocks in total.
                if (r_wait == 4'd0) begin
                    w_state_next = ST_DONE;
                    if (!r_write) begin
                        w_rdata_next = bus.mem_din;
                    end
                    w_p0_done_next = ~r_grant;
                    w_p1_done_next = r_grant;
                end else begin
                    w_wait_next = r_wait - 4'd1;
                end
            end

            ST_DONE: begin
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Chip enable spans SETUP..DONE; IDLE is the bus turnaround clock.
        w_mem_ce_next      = (w_state_next == ST_IDLE);
        w_mem_oe_next      = ~(~w_write_next &
                               ((w_state_next == ST_SETUP) || (w_state_next == ST_STROBE)));
        w_mem_we_next      = ~(w_write_next & (w_state_next == ST_STROBE));
        // Data stays driven through DONE to cover the SRAM write hold time.
        w_mem_dout_en_next = w_write_next & (w_state_next != ST_IDLE);
    end

    // ------------------------------------------------------------------------
    // Context, counter, read data and pin registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_write       <= 1'b0;
            r_grant       <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_dout    <= '0;
            r_wait        <= 4'd0;
            r_rdata       <= '0;
            r_mem_ce      <= 1'b1;
            r_mem_oe      <= 1'b1;
            r_mem_we      <= 1'b1;
            r_mem_dout_en <= 1'b0;
            r_p0_done     <= 1'b0;
            r_p1_done     <= 1'b0;
        end else begin
            r_write       <= w_write_next;
            r_grant       <= w_grant_next;
            r_mem_addr    <= w_mem_addr_next;
            r_mem_dout    <= w_mem_dout_next;
            r_wait        <= w_wait_next;
            r_rdata       <= w_rdata_next;
            r_mem_ce      <= w_mem_ce_next;
            r_mem_oe      <= w_mem_oe_next;
            r_mem_we      <= w_mem_we_next;
            r_mem_dout_en <= w_mem_dout_en_next;
            r_p0_done     <= w_p0_done_next;
            r_p1_done     <= w_p1_done_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.p0_done     = r_p0_done;
    assign bus.p1_done     = r_p1_done;
    assign bus.rdata       = r_rdata;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_dout    = r_mem_dout;
    assign bus.mem_dout_en = r_mem_dout_en;
    assign bus.mem_ce      = r_mem_ce;
    assign bus.mem_oe      = r_mem_oe;
    assign bus.mem_we      = r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Self-checking bench for sram_arbiter. Each scenario task drives
//            requests, pushes the expected completion (port, rdata) onto a
//            scoreboard and pops it when a done pulse appears. Pin strobes are
//            checked clock by clock against the access timeline.
//
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam int WS = 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic          port;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_rdata = '0;

    sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WAIT_STATES(WS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // {ce, oe, we, dout_en, p0_done, p1_done}
    function automatic logic [5:0] obs_vec();
        return {bus.mem_ce, bus.mem_oe, bus.mem_we, bus.mem_dout_en, bus.p0_done, bus.p1_done};
    endfunction

    // Expected pins k clocks after the grant edge
    function automatic logic [5:0] exp_vec(input int k, input logic wr, input logic port);
        if (k == 0)      return {1'b0, wr, 1'b1, wr, 2'b00};          // SETUP
        if (k <= WS + 1) return {1'b0, wr, ~wr, wr, 2'b00};           // STROBE
        if (k == WS + 2) return {1'b0, 1'b1, 1'b1, wr, ~port, port};  // DONE
        return 6'b111000;                                             // IDLE
    endfunction

    task automatic drive_port(input logic port, input logic valid, input logic wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port) begin
            bus.p1_valid = valid; bus.p1_write = wr; bus.p1_addr = a; bus.p1_wdata = d;
        end else begin
            bus.p0_valid = valid; bus.p0_write = wr; bus.p0_addr = a; bus.p0_wdata = d;
        end
    endtask

    task automatic set_valid(input logic port, input logic v);
        if (port) bus.p1_valid = v;
        else      bus.p0_valid = v;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_rdata = '0;
        sb.delete();
    endtask

    // One complete access; entered at a negedge while the DUT is idle, returns
    // at the negedge of the turnaround IDLE clock.
    task automatic access(input logic port, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] din,
                          input logic drop, output int grant_cyc,
                          output int we_low, output int oe_low);
        exp_t e;
        logic [5:0] got;
        logic [5:0] want;
        we_low = 0;
        oe_low = 0;
        grant_cyc = 0;
        drive_port(port, 1'b1, wr, a, wd);
        bus.mem_din = din;
        e.port  = port;
        e.rdata = wr ? model_rdata : din;
        if (!wr) model_rdata = din;
        sb.push_back(e);
        for (int k = 0; k <= WS + 3; k++) begin
            @(negedge clock);
            if (k == 0) grant_cyc = cyc;
            got  = obs_vec();
            want = exp_vec(k, wr, port);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL strobes k=%0d port=%0d wr=%0d got %b want %b", k, port, wr, got, want);
            end
            if (!bus.mem_we) we_low++;
            if (!bus.mem_oe) oe_low++;
            if (k <= WS + 2) begin
                checks++;
                if (bus.mem_addr !== a) begin
                    errors++;
                    $display("FAIL mem_addr k=%0d got %h want %h", k, bus.mem_addr, a);
                end
                if (wr) begin
                    checks++;
                    if (bus.mem_dout !== wd) begin
                        errors++;
                        $display("FAIL mem_dout k=%0d got %h want %h", k, bus.mem_dout, wd);
                    end
                end
            end
            if (k == 0) begin
                // Disturb requester inputs: the access must stay frozen.
                if (drop) set_valid(port, 1'b0);
                else      drive_port(port, 1'b1, ~wr, ~a, ~wd);
            end
            if (k == WS + 2) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard empty at done, got rdata %h want entry", bus.rdata);
                end else begin
                    e = sb.pop_front();
                    if (bus.rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL rdata got %h want %h", bus.rdata, e.rdata);
                    end
                end
                drive_port(port, 1'b0, wr, a, wd);
            end
        end
    endtask

    task automatic test_reset();
        logic [5:0] got;
        got = obs_vec();
        checks++;
        if (got !== 6'b111000) begin
            errors++;
            $display("FAIL reset_strobes got %b want %b", got, 6'b111000);
        end
        checks++;
        if (bus.mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_addr got %h want 0", bus.mem_addr);
        end
        checks++;
        if (bus.mem_dout !== '0) begin
            errors++;
            $display("FAIL reset_dout got %h want 0", bus.mem_dout);
        end
        checks++;
        if (bus.rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata got %h want 0", bus.rdata);
        end
    endtask

    task automatic test_write();
        int g, wl, ol;
        access(1'b1, 1'b1, 19'h12345, 8'h5A, 8'h00, 1'b0, g, wl, ol);
        checks++;
        if (wl != WS + 1) begin
            errors++;
            $display("FAIL write_we_low got %0d want %0d", wl, WS + 1);
        end
        checks++;
        if (ol != 0) begin
            errors++;
            $display("FAIL write_oe_low got %0d want 0", ol);
        end
    endtask

    task automatic test_read();
        int g, wl, ol;
        access(1'b0, 1'b0, 19'h00010, 8'h00, 8'hC3, 1'b0, g, wl, ol);
        checks++;
        if (ol != WS + 2) begin
            errors++;
            $display("FAIL read_oe_low got %0d want %0d", ol, WS + 2);
        end
        checks++;
        if (wl != 0) begin
            errors++;
            $display("FAIL read_we_low got %0d want 0", wl);
        end
    endtask

    task automatic test_back_to_back();
        int g[3];
        int wl, ol;
        for (int i = 0; i < 3; i++) begin
            access(1'b0, 1'b0, AW'(19'h00100 + i), 8'h00, 8'(8'h40 + i), 1'b0, g[i], wl, ol);
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (g[i] - g[i-1] != WS + 4) begin
                errors++;
                $display("FAIL b2b_period[%0d] got %0d want %0d", i, g[i] - g[i-1], WS + 4);
            end
        end
    endtask

    task automatic test_drop();
        int g, wl, ol;
        logic [5:0] got;
        access(1'b1, 1'b1, 19'h00777, 8'h99, 8'h00, 1'b1, g, wl, ol);
        for (int i = 0; i < WS + 5; i++) begin
            @(negedge clock);
            got = obs_vec();
            checks++;
            if (got !== 6'b111000) begin
                errors++;
                $display("FAIL drop_idle i=%0d got %b want %b", i, got, 6'b111000);
            end
        end
    endtask

    task automatic test_reset_mid();
        int g, wl, ol;
        logic [5:0] got;
        drive_port(1'b1, 1'b1, 1'b1, 19'h00ABC, 8'h77);
        @(negedge clock);                 // SETUP
        @(negedge clock);                 // STROBE
        checks++;
        if (bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL midrst_we_before got %b want 0", bus.mem_we);
        end
        reset = 1'b1;
        set_valid(1'b1, 1'b0);
        @(negedge clock);
        got = obs_vec();
        checks++;
        if (got !== 6'b111000) begin
            errors++;
            $display("FAIL midrst_after got %b want %b", got, 6'b111000);
        end
        reset = 1'b0;
        model_rdata = '0;
        for (int i = 0; i < WS + 5; i++) begin
            @(negedge clock);
            checks++;
            if ((bus.p0_done | bus.p1_done | ~bus.mem_ce) !== 1'b0) begin
                errors++;
                $display("FAIL midrst_quiet i=%0d got %b want %b", i, obs_vec(), 6'b111000);
            end
        end
        access(1'b1, 1'b0, 19'h00ABC, 8'h00, 8'h5E, 1'b0, g, wl, ol);
    endtask

    task automatic test_priority();
        int   order[6];
        int   left0;
        int   left1;
        bit   finished;
        exp_t e;
        left0 = 3;
        left1 = 3;
        finished = 1'b0;
        pulse_reset();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        order = '{0, 1, 0, 1, 0, 1};
`else
        order = '{0, 0, 0, 1, 1, 1};
`endif
        bus.mem_din = 8'h3C;
        for (int i = 0; i < 6; i++) begin
            e.port  = order[i][0];
            e.rdata = 8'h3C;
            sb.push_back(e);
        end
        drive_port(1'b0, 1'b1, 1'b0, 19'h01000, 8'h00);
        drive_port(1'b1, 1'b1, 1'b0, 19'h02000, 8'h00);
        for (int c = 0; c < 200 && !finished; c++) begin
            @(negedge clock);
            if (bus.p0_done | bus.p1_done) begin
                checks++;
                if (sb.size() == 0 || (bus.p0_done & bus.p1_done)) begin
                    errors++;
                    $display("FAIL prio_done got p0=%b p1=%b want one expected grant",
                             bus.p0_done, bus.p1_done);
                end else begin
                    e = sb.pop_front();
                    if ({bus.p1_done, bus.rdata} !== {e.port, e.rdata}) begin
                        errors++;
                        $display("FAIL prio_grant got port %0d rdata %h want port %0d rdata %h",
                                 bus.p1_done, bus.rdata, e.port, e.rdata);
                    end
                    if (bus.p1_done) begin
                        left1--;
                        if (left1 == 0) set_valid(1'b1, 1'b0);
                    end else begin
                        left0--;
                        if (left0 == 0) set_valid(1'b0, 1'b0);
                    end
                end
                finished = (left0 <= 0) && (left1 <= 0);
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL prio_timeout got %0d/%0d left want 0/0", left0, left1);
        end
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        drive_port(1'b0, 1'b0, 1'b0, '0, '0);
        drive_port(1'b1, 1'b0, 1'b0, '0, '0);
        bus.mem_din = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        test_reset();
        reset = 1'b0;
        @(negedge clock);
        test_write();
        test_read();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        test_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
